// File: rtl/simd_lane_stager.sv
// simd_lane_stager: gathers one result per lane, issues them to the SIMD core, then streams the processed lanes out
//   clk, reset_poweron_n                 : clock, asynchronous active-low reset
//   cntl__smdw__cfg_*, smdw__cntl__cfg_ready : job config (lane enable mask, operation), accepted only when idle
//   stOp__smdw__valid/data               : per-lane result strobes and data from the streaming-op lanes
//   smdw__simd__*                        : one-cycle issue of operation, enable mask and collected registers
//   simd__smdw__complete/regs            : SIMD completion pulse with processed registers
//   smdw__dn__*, dn__smdw__ready         : valid/ready stream of enabled lanes, ascending lane order
//   smdw__cntl__complete, smdw__cntl__error : end-of-job pulse, sticky error (duplicate lane or SIMD timeout)
module simd_lane_stager #(
    parameter int NUM_LANES  = 32,
    parameter int LANE_WIDTH = 32,
    parameter int CNTL_WIDTH = 2,
    parameter int OP_WIDTH   = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                             clk,
    input  logic                             reset_poweron_n,
    input  logic                             cntl__smdw__cfg_valid,
    input  logic [NUM_LANES-1:0]             cntl__smdw__cfg_lane_enable,
    input  logic [OP_WIDTH-1:0]              cntl__smdw__cfg_operation,
    output logic                             smdw__cntl__cfg_ready,
    input  logic [NUM_LANES-1:0]             stOp__smdw__valid,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]  stOp__smdw__data,
    output logic                             smdw__simd__cfg_valid,
    output logic [OP_WIDTH-1:0]              smdw__simd__cfg_operation,
    output logic [NUM_LANES-1:0]             smdw__simd__regs_valid,
    output logic [NUM_LANES*LANE_WIDTH-1:0]  smdw__simd__regs,
    input  logic                             simd__smdw__complete,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]  simd__smdw__regs,
    output logic                             smdw__dn__valid,
    output logic [CNTL_WIDTH-1:0]            smdw__dn__cntl,
    output logic [LANE_WIDTH-1:0]            smdw__dn__data,
    output logic [$clog2(NUM_LANES)-1:0]     smdw__dn__lane,
    input  logic                             dn__smdw__ready,
    output logic                             smdw__cntl__complete,
    output logic                             smdw__cntl__error
);
    localparam int LW = $clog2(NUM_LANES);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    logic [2:0]                            state;
    logic [NUM_LANES-1:0]                  en, arr, arriving, dup;
    logic [OP_WIDTH-1:0]                   op;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0]  col, res, st_data;
    logic [9:0]                            cnt;
    logic [LW-1:0]                         cur, first_ln, nxt_ln;
    logic                                  has_nxt, first, err;

    assign st_data  = stOp__smdw__data;
    assign arriving = stOp__smdw__valid & en & ~arr;
    assign dup      = stOp__smdw__valid & en & arr;

    // lowest enabled lane (drain start) and next enabled lane above the one on the bus
    always_comb begin
        first_ln = '0;
        nxt_ln   = '0;
        has_nxt  = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (en[i]) first_ln = LW'(i);
            if (en[i] && i > int'(cur)) begin
                nxt_ln  = LW'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state <= S_IDLE;
            en    <= '0;
            arr   <= '0;
            op    <= '0;
            col   <= '0;
            res   <= '0;
            cnt   <= '0;
            cur   <= '0;
            first <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cntl__smdw__cfg_valid) begin
                    en    <= cntl__smdw__cfg_lane_enable;
                    op    <= cntl__smdw__cfg_operation;
                    arr   <= '0;
                    col   <= '0;
                    state <= |cntl__smdw__cfg_lane_enable ? S_COLLECT : S_DONE;
                end
                S_COLLECT: begin
                    for (int i = 0; i < NUM_LANES; i++)
                        if (arriving[i]) col[i] <= st_data[i];
                    arr <= arr | arriving;
                    if (|dup) err <= 1'b1;
                    if ((arr | arriving) == en) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (simd__smdw__complete) begin
                    res   <= simd__smdw__regs;
                    cur   <= first_ln;
                    first <= 1'b1;
                    state <= S_DRAIN;
                end else if (cnt == 10'(TIMEOUT)) begin
                    err   <= 1'b1;
                    state <= S_ERR;
                end else begin
                    cnt <= cnt + 10'd1;
                end
                S_DRAIN: if (dn__smdw__ready) begin
                    first <= 1'b0;
                    cur   <= nxt_ln;
                    if (!has_nxt) state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_ERR;
            endcase
        end
    end

    // all outputs come from registered state only, so ready never feeds valid combinationally
    assign smdw__cntl__cfg_ready     = state == S_IDLE;
    assign smdw__simd__cfg_valid     = state == S_ISSUE;
    assign smdw__simd__cfg_operation = op;
    assign smdw__simd__regs_valid    = state == S_ISSUE ? en : '0;
    assign smdw__simd__regs          = state == S_ISSUE ? col : '0;
    assign smdw__dn__valid           = state == S_DRAIN;
    // {last, first}: MOM=00, SOM=01, EOM=10, SOM_EOM=11
    assign smdw__dn__cntl            = state == S_DRAIN ? CNTL_WIDTH'({!has_nxt, first}) : '0;
    assign smdw__dn__data            = state == S_DRAIN ? res[cur] : '0;
    assign smdw__dn__lane            = state == S_DRAIN ? cur : '0;
    assign smdw__cntl__complete      = state == S_DONE;
    assign smdw__cntl__error         = err;
endmodule

// File: tb/tb_simd_lane_stager.sv
// tb_simd_lane_stager: randomized self-checking bench for simd_lane_stager against a job-level reference model
module tb_simd_lane_stager;
    localparam int NL = 4;
    logic              clk, rst_n;
    logic              cfg_valid, cfg_ready;
    logic [NL-1:0]     cfg_en;
    logic [7:0]        cfg_op, s_op;
    logic [NL-1:0]     st_valid, s_regs_valid;
    logic [NL*32-1:0]  st_data, s_regs, s_res;
    logic              s_cfg_valid, s_complete;
    logic              dn_valid, dn_ready, done, err;
    logic [1:0]        dn_cntl, dn_lane;
    logic [31:0]       dn_data;
    int                n_chk = 0, n_err = 0;
    logic              err_m;
    logic [31:0]       dir_vals[NL];

    simd_lane_stager #(.NUM_LANES(NL), .LANE_WIDTH(32), .CNTL_WIDTH(2), .OP_WIDTH(8), .TIMEOUT(1023)) dut (
        .clk(clk),
        .reset_poweron_n(rst_n),
        .cntl__smdw__cfg_valid(cfg_valid),
        .cntl__smdw__cfg_lane_enable(cfg_en),
        .cntl__smdw__cfg_operation(cfg_op),
        .smdw__cntl__cfg_ready(cfg_ready),
        .stOp__smdw__valid(st_valid),
        .stOp__smdw__data(st_data),
        .smdw__simd__cfg_valid(s_cfg_valid),
        .smdw__simd__cfg_operation(s_op),
        .smdw__simd__regs_valid(s_regs_valid),
        .smdw__simd__regs(s_regs),
        .simd__smdw__complete(s_complete),
        .simd__smdw__regs(s_res),
        .smdw__dn__valid(dn_valid),
        .smdw__dn__cntl(dn_cntl),
        .smdw__dn__data(dn_data),
        .smdw__dn__lane(dn_lane),
        .dn__smdw__ready(dn_ready),
        .smdw__cntl__complete(done),
        .smdw__cntl__error(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_en = '0; cfg_op = '0;
        st_valid = '0; st_data = '0;
        s_complete = 1'b0; s_res = '0; dn_ready = 1'b0;
        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_issue", s_cfg_valid, 0);
        chk("rst_op", s_op, 0);
        chk("rst_regs_valid", s_regs_valid, 0);
        chk("rst_regs", s_regs, 0);
        chk("rst_dn_valid", dn_valid, 0);
        chk("rst_dn_cntl", dn_cntl, 0);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_dn_lane", dn_lane, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        err_m = 1'b0;
        @(negedge clk);
        chk("rst_idle", cfg_ready, 1);
    endtask

    // one job: config, deliver lanes, check issue, answer as SIMD core, check stream and completion
    task automatic run_txn(input logic [NL-1:0] ena, input bit dir, input bit dup, input bit stall,
                           input int abort_after, input bit no_complete);
        logic [31:0]   vals[NL], res[NL];
        logic [127:0]  exp_regs, res_bus;
        logic [NL-1:0] seen;
        logic [7:0]    op;
        int q[$], lanes[$];
        int l, k, n, idx, c, d, delivered, t, j, cnt;
        chk("idle_ready", cfg_ready, 1);
        op = 8'($urandom);
        for (int i = 0; i < NL; i++) begin
            vals[i] = dir ? dir_vals[i] : $urandom;
            res[i]  = dir ? vals[i] : $urandom;
        end
        cfg_valid = 1'b1; cfg_en = ena; cfg_op = op;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_en = '0; cfg_op = '0;
        if (ena == '0) begin
            chk("zero_done", done, 1);
            chk("zero_no_issue", s_cfg_valid, 0);
            @(negedge clk);
            chk("zero_done_pulse", done, 0);
            chk("zero_idle", cfg_ready, 1);
            return;
        end
        chk("cfg_busy", cfg_ready, 0);
        if (!dir) begin
            cfg_valid = 1'b1; cfg_en = ~ena; cfg_op = ~op;
        end
        for (int i = 0; i < NL; i++) if (ena[i]) q.push_back(i);
        if (!dir)
            for (int i = q.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i); t = q[i]; q[i] = q[j]; q[j] = t;
            end
        if (dup && q.size() >= 2) q.insert(1, q[0]);
        seen = '0; delivered = 0; exp_regs = '0;
        for (int i = 0; i < NL; i++) if (ena[i]) exp_regs[i*32 +: 32] = vals[i];
        while (q.size() > 0) begin
            if (!dir && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk("gap_no_issue", s_cfg_valid, 0);
            end
            st_valid = '0;
            st_data = {$urandom, $urandom, $urandom, $urandom};
            l = q.pop_front();
            st_valid[l] = 1'b1;
            st_data[l*32 +: 32] = seen[l] ? ~vals[l] : vals[l];
            if (seen[l]) err_m = 1'b1;
            seen[l] = 1'b1;
            if (!dir && !dup && q.size() > 0 && $urandom_range(0, 1) == 1) begin
                l = q.pop_front();
                st_valid[l] = 1'b1;
                st_data[l*32 +: 32] = vals[l];
                seen[l] = 1'b1;
            end
            if (!dir && ena != '1 && $urandom_range(0, 1) == 1) begin
                do k = $urandom_range(0, NL - 1); while (ena[k]);
                st_valid[k] = 1'b1;
            end
            delivered++;
            @(negedge clk);
            st_valid = '0; cfg_valid = 1'b0; cfg_en = '0; cfg_op = '0;
            if (abort_after == delivered) return;
            if (q.size() > 0) chk("early_issue", s_cfg_valid, 0);
        end
        chk("issue_pulse", s_cfg_valid, 1);
        chk("issue_mask", s_regs_valid, ena);
        chk("issue_op", s_op, op);
        chk("issue_regs", s_regs, exp_regs);
        chk("issue_err", err, err_m);
        @(negedge clk);
        chk("issue_single", s_cfg_valid, 0);
        chk("issue_mask_clr", s_regs_valid, 0);
        if (no_complete) begin
            cnt = 0;
            while (err !== 1'b1 && cnt < 1200) begin
                @(negedge clk);
                cnt++;
            end
            chk("timeout_err", err, 1);
            chk("timeout_not_early", cnt >= 1000, 1);
            chk("err_ready_low", cfg_ready, 0);
            cfg_valid = 1'b1; cfg_en = '1; s_complete = 1'b1;
            @(negedge clk);
            cfg_valid = 1'b0; cfg_en = '0; s_complete = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("err_hold_ready", cfg_ready, 0);
                chk("err_no_issue", s_cfg_valid, 0);
                chk("err_no_beat", dn_valid, 0);
                chk("err_no_done", done, 0);
                chk("err_hold", err, 1);
            end
            err_m = 1'b1;
            return;
        end
        d = dir ? 0 : $urandom_range(0, 3);
        repeat (d) begin
            @(negedge clk);
            chk("wait_no_beat", dn_valid, 0);
        end
        s_complete = 1'b1;
        for (int i = 0; i < NL; i++) res_bus[i*32 +: 32] = res[i];
        s_res = res_bus;
        @(negedge clk);
        s_complete = 1'b0;
        s_res = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NL; i++) if (ena[i]) lanes.push_back(i);
        n = lanes.size(); idx = 0; c = 0;
        while (idx < n) begin
            chk("beat_valid", dn_valid, 1);
            chk("beat_lane", dn_lane, lanes[idx]);
            chk("beat_data", dn_data, res[lanes[idx]]);
            chk("beat_cntl", dn_cntl, n == 1 ? 3 : idx == 0 ? 1 : idx == n - 1 ? 2 : 0);
            dn_ready = stall ? (c % 3 == 0) : 1'b1;
            c++;
            if (dn_ready) idx++;
            @(negedge clk);
        end
        dn_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_no_beat", dn_valid, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("back_idle", cfg_ready, 1);
        chk("err_sticky", err, err_m);
    endtask

    initial begin
        rst_n = 1'b1;
        cfg_valid = 1'b0; cfg_en = '0; cfg_op = '0;
        st_valid = '0; st_data = '0;
        s_complete = 1'b0; s_res = '0; dn_ready = 1'b0;
        err_m = 1'b0;
        #2;
        do_reset();
        dir_vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        run_txn(4'hF, 1, 0, 0, -1, 0);
        dir_vals[2] = 32'h41200000;
        run_txn(4'b0100, 1, 0, 0, -1, 0);
        run_txn(4'b0101, 1, 1, 0, -1, 0);
        run_txn(4'hF, 0, 0, 1, -1, 0);
        for (int r = 0; r < 20; r++)
            run_txn(4'($urandom_range(0, 15)), 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), -1, 0);
        run_txn(4'hF, 1, 0, 0, 2, 0);
        do_reset();
        run_txn(4'hF, 0, 0, 0, -1, 0);
        run_txn(4'hF, 0, 0, 0, -1, 1);
        do_reset();
        run_txn(4'b1010, 0, 0, 1, -1, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/simd_lane_stager.md
Name: simd_lane_stager

Overview:
- Upstream/downstream companion of the PE SIMD core.
- Collects one result per execution lane from the streaming-op lanes and issues the full lane-register set to the SIMD core in a single cycle.
- Waits for SIMD completion, captures the processed lane registers, then serialises the enabled lanes onto a valid/ready output stream toward the PE NoC/memory path.

Parameters:
NUM_LANES, 32, execution lanes (matches PE_NUM_OF_EXEC_LANES)
LANE_WIDTH, 32, bits per lane (IEEE-754 single)
CNTL_WIDTH, 2, std-interface cntl width (SOM/MOM/EOM/SOM_EOM encodings from common.vh)
OP_WIDTH, 8, SIMD operation word width
TIMEOUT, 1023, max cycles to wait for SIMD completion

Ports:
clk  in  1  clock
reset_poweron_n  in  1  asynchronous active-low reset
cntl__smdw__cfg_valid  in  1  config strobe
cntl__smdw__cfg_lane_enable  in  NUM_LANES  lanes taking part
cntl__smdw__cfg_operation  in  OP_WIDTH  SIMD operation
smdw__cntl__cfg_ready  out  1  high only in IDLE
stOp__smdw__valid  in  NUM_LANES  per-lane result strobe
stOp__smdw__data  in  NUM_LANES*LANE_WIDTH  per-lane results, lane0 at LSBs
smdw__simd__cfg_valid  out  1  one-cycle issue pulse to SIMD core
smdw__simd__cfg_operation  out  OP_WIDTH  latched operation
smdw__simd__regs_valid  out  NUM_LANES  enable mask, pulsed with cfg_valid
smdw__simd__regs  out  NUM_LANES*LANE_WIDTH  collected lane registers
simd__smdw__complete  in  1  SIMD done pulse
simd__smdw__regs  in  NUM_LANES*LANE_WIDTH  SIMD result regs, valid when complete=1
smdw__dn__valid  out  1  output beat valid
smdw__dn__cntl  out  CNTL_WIDTH  SOM/MOM/EOM/SOM_EOM
smdw__dn__data  out  LANE_WIDTH  output lane value
smdw__dn__lane  out  clog2(NUM_LANES)  lane index of beat
dn__smdw__ready  in  1  downstream accept
smdw__cntl__complete  out  1  one-cycle pulse after last beat
smdw__cntl__error  out  1  sticky error

Behaviour:
- Reset (async, active low): state IDLE; all outputs 0 except cfg_ready=1; arrived mask, enable mask, regs and error cleared. Reset mid-operation aborts without emitting a complete pulse.
- States: IDLE, COLLECT, ISSUE, WAIT_SIMD, DRAIN, DONE, ERR.
- IDLE: cfg_ready=1. On cfg_valid, latch lane_enable and operation, clear arrived mask.
  - Nonzero mask -> COLLECT.
  - Zero mask -> DONE.
  - cfg_valid outside IDLE is ignored.
- COLLECT: on a stOp valid bit for an enabled, not-yet-arrived lane, latch data and set the arrived bit.
  - Valid on a disabled lane: ignored.
  - Valid on an already-arrived lane: data dropped, error set (stays in COLLECT).
  - Multiple lanes arriving in the same cycle are all accepted.
  - When (arrived | arriving) == enable -> ISSUE next cycle.
- ISSUE: one cycle. cfg_valid=1, regs_valid=enable, regs=collected values (disabled lanes 0). -> WAIT_SIMD.
- WAIT_SIMD: 10-bit cycle counter from 0.
  - On complete=1: capture simd__smdw__regs the same cycle -> DRAIN.
  - If counter reaches TIMEOUT with no complete: error=1 -> ERR.
  - complete seen in any other state is ignored.
- DRAIN: emit enabled lanes in ascending index order, one beat per accepted transfer.
  - valid held with data/cntl/lane stable until ready=1; no combinational ready->valid path.
  - cntl: first beat SOM, last beat EOM, middle beats MOM, single enabled lane SOM_EOM.
  - After last accepted beat -> DONE.
- DONE: complete=1 for one cycle -> IDLE.
- ERR: cfg_ready=0, all valids 0; held until reset.
- Latency (SIMD completes instantly, ready tied high): last lane arrival -> ISSUE +1 cycle; complete -> first beat +1 cycle; N enabled lanes drain in N cycles.

Test Plan:
- NUM_LANES=4, enable=4'b1111, lanes arrive 0x3F800000/0x40000000/0x40400000/0x40800000 on separate cycles -> single ISSUE pulse with regs_valid=4'hF and those values; SIMD returns same values -> 4 beats SOM,MOM,MOM,EOM, lanes 0..3; complete pulse one cycle after beat 3.
- enable=4'b0100, lane 2 = 0x41200000 -> one beat, cntl SOM_EOM, lane=2.
- enable=4'b0101, lane 0 valid twice before lane 2 -> second lane-0 value dropped, error=1, issued lane 0 = first value.
- Downstream ready toggled 1,0,0,1,... during DRAIN -> beats held stable while stalled, no lane lost or duplicated, order 0..3.
- complete withheld for TIMEOUT cycles -> error=1, state ERR, cfg_ready=0; only reset clears.
- Assert reset_poweron_n low in COLLECT (2 of 4 lanes arrived) -> outputs return to reset values immediately; new cfg then completes normally.
